// File: rtl/ram_banked_port_pkg.sv
// Shared definitions for the banked data RAM.
// Contents: FSM state encodings, pipeline tag struct, legal read-latency
// bounds and constant helpers for index/offset widths.
package ram_banked_port_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   // Per-request bookkeeping that travels alongside the read data.
   typedef struct packed {
      logic valid;
      logic is_read;
      logic err;
   } rd_tag_t;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Word-index width; never narrower than one bit.
   function automatic int idx_w(input int depth);
      return (depth > 1) ? clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ram_banked_port_if.sv
// Request/response, clear and debug signals of the banked data RAM.
// master: requester side (drives req_*, clear, dbg_index).
// slave : RAM side (drives req_ready, resp_*, busy, dbg_rdata).
interface ram_banked_port_if
   import ram_banked_port_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 128
);
   localparam int IW   = idx_w(DEPTH);
   localparam int BE_W = DATA_WIDTH / 8;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [BE_W-1:0]       req_be;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;
   logic                  clear;
   logic                  busy;
   logic [IW-1:0]         dbg_index;
   logic [DATA_WIDTH-1:0] dbg_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, clear, dbg_index,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy, dbg_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, clear, dbg_index,
      output req_ready, resp_valid, resp_rdata, resp_err, busy, dbg_rdata
   );

endinterface

// File: rtl/ram_banked_port_rd_pipe.sv
// Delay line for response bookkeeping and read data.
// Ports: clk/rst (async, active-high), i_tag/i_data in, o_tag/o_data out
// after STAGES clocks. STAGES=0 degenerates to a wire.
module ram_banked_port_rd_pipe
   import ram_banked_port_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  rd_tag_t               i_tag,
   input  logic [DATA_WIDTH-1:0] i_data,
   output rd_tag_t               o_tag,
   output logic [DATA_WIDTH-1:0] o_data
);

   generate
      if (STAGES == 0) begin : g_bypass
         assign o_tag  = i_tag;
         assign o_data = i_data;
      end else begin : g_shift
         rd_tag_t [STAGES-1:0]                 r_tag;
         logic    [STAGES-1:0][DATA_WIDTH-1:0] r_data;

         // Reset drops anything in flight: valid bits go to zero.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_tag  <= '0;
               r_data <= '0;
            end else begin
               r_tag[0]  <= i_tag;
               r_data[0] <= i_data;
               for (int s = 1; s < STAGES; s++) begin
                  r_tag[s]  <= r_tag[s-1];
                  r_data[s] <= r_data[s-1];
               end
            end
         end

         assign o_tag  = r_tag[STAGES-1];
         assign o_data = r_data[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/ram_banked_port.sv
// Single-port data RAM with byte-addressed valid/ready requests, per-byte
// write enables, fixed read latency, in-order responses, misalign/range
// error detection, a zeroing sweep (on reset or on request) and a
// registered debug read port.
// Ports: clk, rst (async, active-high), bus (ram_banked_port_if.slave).
module ram_banked_port
   import ram_banked_port_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int DEPTH          = 128,
   parameter int READ_LATENCY   = 2,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst,
   ram_banked_port_if.slave  bus
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF   = clog2(BYTES);
   localparam int IW    = idx_w(DEPTH);
   // Out-of-range latency settings are pinned to the nearest legal value.
   localparam int LAT   = (READ_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                          (READ_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : READ_LATENCY;
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   state_t                r_state;
   logic                  r_ready;
   logic                  r_busy;
   logic [IW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_acc;
   logic                  w_misal;
   logic                  w_oor;
   logic                  w_err;
   logic [ADDR_WIDTH-1:0] w_word;
   logic [IW-1:0]         w_idx;

   rd_tag_t               r_cap_tag;
   logic [DATA_WIDTH-1:0] r_cap_data;
   rd_tag_t               w_pipe_tag;
   logic [DATA_WIDTH-1:0] w_pipe_data;

   logic                  r_resp_valid;
   logic                  r_resp_err;
   logic [DATA_WIDTH-1:0] r_resp_rdata;
   logic [DATA_WIDTH-1:0] r_dbg;

   // A clear pulse in IDLE wins over a same-cycle request, so it has to
   // mask ready combinationally in that very cycle.
   assign bus.req_ready = r_ready & ~bus.clear;
   assign w_acc         = bus.req_valid & bus.req_ready;

   assign w_word  = bus.req_addr >> OFF;
   assign w_idx   = w_word[IW-1:0];
   assign w_misal = (bus.req_addr & ADDR_WIDTH'(BYTES - 1)) != '0;
   assign w_oor   = w_word >= ADDR_WIDTH'(DEPTH);
   assign w_err   = w_misal | w_oor;

   // Control FSM: IDLE serves requests, CLEAR zeroes one word per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         r_busy  <= (CLEAR_ON_RESET != 0);
         r_ready <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.clear) begin
                  r_state <= ST_CLEAR;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (r_cnt == LAST) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // Storage is deliberately not reset; the sweep handles zeroing.
   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) begin
         r_mem[r_cnt] <= '0;
      end else if (w_acc && bus.req_write && !w_err) begin
         for (int b = 0; b < BYTES; b++)
            if (bus.req_be[b]) r_mem[w_idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
      end
   end

   // Sample the array at the accepting edge; a write one cycle earlier is
   // already in the array, so no bypass is needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cap_tag  <= '0;
         r_cap_data <= '0;
      end else begin
         r_cap_tag  <= '{valid: w_acc, is_read: ~bus.req_write, err: w_err};
         r_cap_data <= r_mem[w_idx];
      end
   end

   ram_banked_port_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (LAT - 1)
   ) u_rd_pipe (
      .clk    (clk),
      .rst    (rst),
      .i_tag  (r_cap_tag),
      .i_data (r_cap_data),
      .o_tag  (w_pipe_tag),
      .o_data (w_pipe_data)
   );

   // Final output register; data only escapes for error-free reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_resp_valid <= w_pipe_tag.valid;
         r_resp_err   <= w_pipe_tag.valid & w_pipe_tag.err;
         r_resp_rdata <= (w_pipe_tag.valid & w_pipe_tag.is_read & ~w_pipe_tag.err) ?
                         w_pipe_data : '0;
      end
   end

   // Debug read returns pre-edge contents when the same word is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_dbg <= '0;
      else if (32'(bus.dbg_index) < DEPTH)    r_dbg <= r_mem[bus.dbg_index];
      else                                    r_dbg <= '0;
   end

   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_err   = r_resp_err;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.busy       = r_busy;
   assign bus.dbg_rdata  = r_dbg;

endmodule
